// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Consumes the countdown chain's top-digit borrow pulse. While armed, an
// expiry starts a beeping buzzer that times out after RING_TICKS ticks,
// can be snoozed a limited number of times, and can be stopped outright.
// Every output is a flop updated in the same single state-machine process.
module alarm_sequencer #(
  parameter int RING_TICKS   = 30,
  parameter int SNOOZE_TICKS = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int CW           = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       borrow_in,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic [1:0] state,
  output logic       buzzer,
  output logic       ringing,
  output logic [2:0] snooze_left,
  output logic       missed
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_RINGING = 2'b10,
    S_SNOOZE  = 2'b11
  } state_t;

  localparam logic [CW-1:0] RING_LOAD   = CW'(RING_TICKS);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_TICKS);
  localparam logic [2:0]    SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t        state_reg;
  logic [CW-1:0] ring_cnt_reg;
  logic [CW-1:0] snz_cnt_reg;

  assign state = state_reg;

  // Alarm state machine; counters are loaded on entry to their state and only
  // count down on tick while in it, so they never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      buzzer       <= 1'b0;
      ringing      <= 1'b0;
      missed       <= 1'b0;
      snooze_left  <= SNOOZE_MAX;
      ring_cnt_reg <= '0;
      snz_cnt_reg  <= '0;
    end else if (!arm) begin
      // Disarm overrides every other input; the missed flag is kept so the
      // user can still see that the last alarm went unanswered.
      state_reg <= S_IDLE;
      buzzer    <= 1'b0;
      ringing   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // arm is known high here: start a fresh alarm event.
          state_reg   <= S_ARMED;
          missed      <= 1'b0;
          snooze_left <= SNOOZE_MAX;
        end

        S_ARMED: begin
          if (borrow_in) begin
            state_reg    <= S_RINGING;
            ring_cnt_reg <= RING_LOAD;
            buzzer       <= 1'b1;
            ringing      <= 1'b1;
          end
        end

        S_RINGING: begin
          if (stop) begin
            state_reg <= S_IDLE;
            buzzer    <= 1'b0;
            ringing   <= 1'b0;
            missed    <= 1'b0;
          end else if (snooze && (snooze_left != 3'd0)) begin
            state_reg   <= S_SNOOZE;
            snz_cnt_reg <= SNOOZE_LOAD;
            snooze_left <= snooze_left - 3'd1;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
          end else if (tick) begin
            // A snooze request with no snoozes left falls through to here,
            // so the ring keeps being timed normally.
            if (ring_cnt_reg <= CW'(1)) begin
              state_reg <= S_IDLE;
              buzzer    <= 1'b0;
              ringing   <= 1'b0;
              missed    <= 1'b1;
            end else begin
              ring_cnt_reg <= ring_cnt_reg - CW'(1);
              buzzer       <= ~buzzer;
            end
          end
        end

        S_SNOOZE: begin
          if (stop) begin
            state_reg <= S_IDLE;
          end else if (tick) begin
            if (snz_cnt_reg <= CW'(1)) begin
              state_reg    <= S_RINGING;
              ring_cnt_reg <= RING_LOAD;
              buzzer       <= 1'b1;
              ringing      <= 1'b1;
            end else begin
              snz_cnt_reg <= snz_cnt_reg - CW'(1);
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
          buzzer    <= 1'b0;
          ringing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; an independent monitor pops and compares on the falling edge.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       borrow_in = 1'b0;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] state;
  logic       buzzer;
  logic       ringing;
  logic [2:0] snooze_left;
  logic       missed;

  alarm_sequencer #(
    .RING_TICKS(30), .SNOOZE_TICKS(5), .MAX_SNOOZE(3), .CW(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .borrow_in(borrow_in), .arm(arm),
    .snooze(snooze), .stop(stop), .state(state), .buzzer(buzzer),
    .ringing(ringing), .snooze_left(snooze_left), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tgt;
    string      nm;
    logic [1:0] st;
    logic       bz;
    logic       rg;
    logic [2:0] sl;
    logic       ms;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that targets the cycle just completed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 1;
      if (e.tgt == cyc && state === e.st && buzzer === e.bz && ringing === e.rg &&
          snooze_left === e.sl && missed === e.ms) begin
        passed = passed + 1;
        $display("cyc %0d %s ok: state=%b buzzer=%b ringing=%b snooze_left=%0d missed=%b",
                 cyc, e.nm, state, buzzer, ringing, snooze_left, missed);
      end else begin
        $display("FAIL %s (cyc %0d, due %0d): got state=%b buzzer=%b ringing=%b snooze_left=%0d missed=%b, expected state=%b buzzer=%b ringing=%b snooze_left=%0d missed=%b",
                 e.nm, cyc, e.tgt, state, buzzer, ringing, snooze_left, missed,
                 e.st, e.bz, e.rg, e.sl, e.ms);
      end
    end
  end

  // Expectation for the outputs after the next rising edge.
  task automatic expect_out(input string nm, input logic [1:0] st, input logic bz,
                            input logic [2:0] sl, input logic ms);
    exp_t e;
    e.tgt = cyc + 1;
    e.nm  = nm;
    e.st  = st;
    e.bz  = bz;
    e.rg  = (st == 2'b10);
    e.sl  = sl;
    e.ms  = ms;
    q.push_back(e);
  endtask

  // Advance one cycle and clear the single-cycle pulses.
  task automatic go();
    @(negedge clk);
    #1;
    tick = 1'b0;
    borrow_in = 1'b0;
    snooze = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #1;

    // 1: reset with inputs toggling
    rst = 1'b0; arm = 1'b1; tick = 1'b1; borrow_in = 1'b1; snooze = 1'b1; stop = 1'b1;
    go();
    rst = 1'b0; arm = 1'b0; tick = 1'b1; borrow_in = 1'b1; snooze = 1'b1; stop = 1'b1;
    expect_out("reset", 2'b00, 1'b0, 3'd3, 1'b0);
    go();
    rst = 1'b1;
    go();
    checks = checks + 1;
    if (state === 2'b00 && buzzer === 1'b0 && snooze_left === 3'd3) begin
      passed = passed + 1;
      $display("cyc %0d idle_after_reset ok: state=%b buzzer=%b snooze_left=%0d",
               cyc, state, buzzer, snooze_left);
    end else begin
      $display("FAIL idle_after_reset (cyc %0d): got state=%b buzzer=%b snooze_left=%0d, expected state=00 buzzer=0 snooze_left=3",
               cyc, state, buzzer, snooze_left);
    end

    // 2: arm, expire, beep pattern, stop
    arm = 1'b1;
    expect_out("armed", 2'b01, 1'b0, 3'd3, 1'b0);
    go();
    borrow_in = 1'b1;
    expect_out("ring_start", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    tick = 1'b1; expect_out("beep1", 2'b10, 1'b0, 3'd3, 1'b0); go();
    tick = 1'b1; expect_out("beep2", 2'b10, 1'b1, 3'd3, 1'b0); go();
    tick = 1'b1; expect_out("beep3", 2'b10, 1'b0, 3'd3, 1'b0); go();
    tick = 1'b1; expect_out("beep4", 2'b10, 1'b1, 3'd3, 1'b0); go();
    stop = 1'b1;
    expect_out("stop", 2'b00, 1'b0, 3'd3, 1'b0);
    go();
    checks = checks + 1;
    if (state === 2'b00 && buzzer === 1'b0 && missed === 1'b0) begin
      passed = passed + 1;
      $display("cyc %0d direct_stop ok: state=%b buzzer=%b missed=%b",
               cyc, state, buzzer, missed);
    end else begin
      $display("FAIL direct_stop (cyc %0d): got state=%b buzzer=%b missed=%b, expected state=00 buzzer=0 missed=0",
               cyc, state, buzzer, missed);
    end
    expect_out("rearm_after_stop", 2'b01, 1'b0, 3'd3, 1'b0);
    go();

    // 3: timeout after RING_TICKS ticks
    borrow_in = 1'b1;
    expect_out("ring_start2", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    for (int k = 1; k <= 29; k++) begin
      tick = 1'b1;
      if (k == 29) expect_out("tick29_still_ringing", 2'b10, 1'b0, 3'd3, 1'b0);
      go();
    end
    tick = 1'b1;
    expect_out("timeout", 2'b00, 1'b0, 3'd3, 1'b1);
    go();
    expect_out("rearm_clears_missed", 2'b01, 1'b0, 3'd3, 1'b0);
    go();

    // 4: three snoozes, fourth ignored
    borrow_in = 1'b1;
    expect_out("ring_start3", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    for (int i = 0; i < 3; i++) begin
      snooze = 1'b1;
      expect_out("snooze", 2'b11, 1'b0, 3'(2 - i), 1'b0);
      go();
      for (int k = 1; k <= 5; k++) begin
        tick = 1'b1;
        if (k == 4) expect_out("snooze_tick4", 2'b11, 1'b0, 3'(2 - i), 1'b0);
        if (k == 5) expect_out("rering", 2'b10, 1'b1, 3'(2 - i), 1'b0);
        go();
      end
    end
    snooze = 1'b1;
    expect_out("snooze_exhausted", 2'b10, 1'b1, 3'd0, 1'b0);
    go();
    snooze = 1'b1; tick = 1'b1;
    expect_out("exhausted_snooze_tick", 2'b10, 1'b0, 3'd0, 1'b0);
    go();
    stop = 1'b1;
    expect_out("stop2", 2'b00, 1'b0, 3'd0, 1'b0);
    go();
    expect_out("rearm_reload", 2'b01, 1'b0, 3'd3, 1'b0);
    go();

    // 5: stop beats snooze; disarm beats borrow
    borrow_in = 1'b1;
    expect_out("ring_start4", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    stop = 1'b1; snooze = 1'b1;
    expect_out("stop_over_snooze", 2'b00, 1'b0, 3'd3, 1'b0);
    go();
    expect_out("armed2", 2'b01, 1'b0, 3'd3, 1'b0);
    go();
    borrow_in = 1'b1; arm = 1'b0;
    expect_out("disarm_over_borrow", 2'b00, 1'b0, 3'd3, 1'b0);
    go();

    // 6: borrow ignored in IDLE and SNOOZE; reset mid-snooze
    borrow_in = 1'b1;
    expect_out("idle_borrow_disarmed", 2'b00, 1'b0, 3'd3, 1'b0);
    go();
    arm = 1'b1; borrow_in = 1'b1;
    expect_out("idle_borrow_armed", 2'b01, 1'b0, 3'd3, 1'b0);
    go();
    borrow_in = 1'b1;
    expect_out("ring_start5", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    snooze = 1'b1;
    expect_out("snooze2", 2'b11, 1'b0, 3'd2, 1'b0);
    go();
    borrow_in = 1'b1;
    expect_out("snooze_borrow", 2'b11, 1'b0, 3'd2, 1'b0);
    go();
    tick = 1'b1;
    expect_out("snooze_tick", 2'b11, 1'b0, 3'd2, 1'b0);
    go();
    rst = 1'b0; tick = 1'b1; stop = 1'b1;
    expect_out("reset_in_snooze", 2'b00, 1'b0, 3'd3, 1'b0);
    go();
    rst = 1'b1;
    expect_out("armed_after_reset", 2'b01, 1'b0, 3'd3, 1'b0);
    go();
    borrow_in = 1'b1;
    expect_out("ring_start6", 2'b10, 1'b1, 3'd3, 1'b0);
    go();
    arm = 1'b0; tick = 1'b1;
    expect_out("disarm_ringing", 2'b00, 1'b0, 3'd3, 1'b0);
    go();

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 1;
      $display("FAIL %s: expectation never compared, got none, expected state=%b", e.nm, e.st);
    end
    checks = checks + 1;
    if (state === 2'b00 && buzzer === 1'b0 && ringing === 1'b0 && missed === 1'b0) begin
      passed = passed + 1;
      $display("cyc %0d final_idle ok: state=%b buzzer=%b ringing=%b missed=%b",
               cyc, state, buzzer, ringing, missed);
    end else begin
      $display("FAIL final_idle (cyc %0d): got state=%b buzzer=%b ringing=%b missed=%b, expected state=00 buzzer=0 ringing=0 missed=0",
               cyc, state, buzzer, ringing, missed);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
